// File: rtl/interrupt_controller_pkg.sv
// Shared constants, state encoding and small helpers for the interrupt controller.
package interrupt_controller_pkg;

    localparam int NUM_LINES = 5;

    localparam logic [15:0] VECTOR_BASE    = 16'hFFF2;
    localparam logic [15:0] VECTOR_STRIDE  = 16'd2;
    localparam logic [15:0] VECTOR_DEFAULT = 16'hFFFE;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_REQ     = 2'b01,
        ST_SERVICE = 2'b10
    } state_t;

    // Fixed priority: the lowest-numbered requesting line wins.
    function automatic logic [NUM_LINES-1:0] pick_highest(input logic [NUM_LINES-1:0] req);
        logic [NUM_LINES-1:0] sel;
        sel = '0;
        for (int i = NUM_LINES - 1; i >= 0; i--) begin
            if (req[i]) begin
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
        return sel;
    endfunction

    function automatic logic [15:0] vector_of(input logic [NUM_LINES-1:0] onehot);
        logic [15:0] v;
        v = VECTOR_DEFAULT;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (onehot[i]) begin
                v = VECTOR_BASE + VECTOR_STRIDE * 16'(i);
            end
        end
        return v;
    endfunction

endpackage

// File: rtl/interrupt_controller_sync_edge.sv
// One interrupt line: two-flop synchronizer plus history flop producing a one-cycle rise pulse.
module int_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign rise = sync2 & ~hist;

endmodule

// File: rtl/interrupt_controller.sv
// Five-line edge-triggered interrupt controller: pending/mask/enable, fixed-priority
// arbitration and an IDLE/REQ/SERVICE request FSM whose state is exported for debug.
module interrupt_controller
    import interrupt_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_LINES-1:0] int_in,
    input  logic [7:0]           data,
    input  logic                 mask_load,
    input  logic                 ei,
    input  logic                 di,
    input  logic                 int_ack,
    input  logic                 int_done,
    output logic                 irq,
    output logic [NUM_LINES-1:0] irq_no,
    output logic [15:0]          vector,
    output logic [NUM_LINES-1:0] pending,
    output state_t               state
);

    logic [NUM_LINES-1:0] rise;
    logic [NUM_LINES-1:0] mask;
    logic                 gie;
    logic [NUM_LINES-1:0] eligible;
    logic [NUM_LINES-1:0] sel;
    logic                 mask_drop;
    logic [NUM_LINES-1:0] ack_clear;
    logic [NUM_LINES-1:0] irq_no_next;
    logic                 irq_next;
    state_t               state_next;

    for (genvar i = 0; i < NUM_LINES; i++) begin : g_line
        int_sync_edge u_sync (
            .clk  (clk),
            .rst  (rst),
            .din  (int_in[i]),
            .rise (rise[i])
        );
    end

    assign eligible  = pending & mask & {NUM_LINES{gie}};
    assign sel       = pick_highest(eligible);
    assign mask_drop = mask_load && ((data[NUM_LINES-1:0] & irq_no) == '0);
    assign vector    = vector_of(irq_no);

    // Handshake: irq stays high in REQ until the control unit answers with a one-cycle
    // int_ack (accepted, move to SERVICE) or the request is withdrawn by di / mask change.
    always_comb begin
        state_next  = state;
        irq_next    = irq;
        irq_no_next = irq_no;
        ack_clear   = '0;
        case (state)
            ST_IDLE: begin
                irq_next = 1'b0;
                if (eligible != '0) begin
                    state_next  = ST_REQ;
                    irq_next    = 1'b1;
                    irq_no_next = sel;
                end
            end
            ST_REQ: begin
                if (int_ack) begin
                    state_next = ST_SERVICE;
                    irq_next   = 1'b0;
                    ack_clear  = irq_no;
                end else if (di || mask_drop) begin
                    state_next  = ST_IDLE;
                    irq_next    = 1'b0;
                    irq_no_next = '0;
                end
            end
            ST_SERVICE: begin
                irq_next = 1'b0;
                if (int_done) begin
                    state_next  = ST_IDLE;
                    irq_no_next = '0;
                end
            end
            default: begin
                state_next  = ST_IDLE;
                irq_next    = 1'b0;
                irq_no_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ST_IDLE;
            irq     <= 1'b0;
            irq_no  <= '0;
            pending <= '0;
            mask    <= '0;
            gie     <= 1'b0;
        end else begin
            state   <= state_next;
            irq     <= irq_next;
            irq_no  <= irq_no_next;
            // A new edge on the line being acknowledged must not be lost.
            pending <= (pending & ~ack_clear) | rise;
            if (mask_load) begin
                mask <= data[NUM_LINES-1:0];
            end
            if (di) begin
                gie <= 1'b0;
            end else if (ei) begin
                gie <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: a per-cycle vector table plus hand-written
// sequences for masking, withdrawal, ack races, priority hold-off and reset.
module tb_interrupt_controller;
    import interrupt_controller_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [4:0]  int_in = '0;
    logic [7:0]  data = '0;
    logic        mask_load = 1'b0;
    logic        ei = 1'b0;
    logic        di = 1'b0;
    logic        int_ack = 1'b0;
    logic        int_done = 1'b0;
    logic        irq;
    logic [4:0]  irq_no;
    logic [15:0] vector;
    logic [4:0]  pending;
    state_t      state;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  in_v;
        logic [7:0]  d;
        logic        ml;
        logic        e;
        logic        dd;
        logic        ack;
        logic        done;
        logic        e_irq;
        logic [4:0]  e_no;
        logic [4:0]  e_pend;
        logic [15:0] e_vec;
    } vec_t;

    vec_t vecs[$];

    interrupt_controller dut (
        .clk       (clk),
        .rst       (rst),
        .int_in    (int_in),
        .data      (data),
        .mask_load (mask_load),
        .ei        (ei),
        .di        (di),
        .int_ack   (int_ack),
        .int_done  (int_done),
        .irq       (irq),
        .irq_no    (irq_no),
        .vector    (vector),
        .pending   (pending),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [4:0] i, input logic [7:0] d, input logic ml,
                         input logic e, input logic dd, input logic a, input logic dn);
        int_in    = i;
        data      = d;
        mask_load = ml;
        ei        = e;
        di        = dd;
        int_ack   = a;
        int_done  = dn;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_vec(input logic [4:0] no);
        case (no)
            5'h01:   return 16'hFFF2;
            5'h02:   return 16'hFFF4;
            5'h04:   return 16'hFFF6;
            5'h08:   return 16'hFFF8;
            5'h10:   return 16'hFFFA;
            default: return 16'hFFFE;
        endcase
    endfunction

    task automatic chk_outs(input string tag, input logic e_irq, input logic [4:0] e_no,
                            input logic [4:0] e_pend);
        chk({tag, ".irq"}, 16'(irq), 16'(e_irq));
        chk({tag, ".irq_no"}, 16'(irq_no), 16'(e_no));
        chk({tag, ".pending"}, 16'(pending), 16'(e_pend));
        chk({tag, ".vector"}, vector, exp_vec(e_no));
    endtask

    task automatic chk_state(input string tag, input state_t exp);
        chk({tag, ".state"}, 16'(state), 16'(exp));
    endtask

    // Pulse a line for one cycle and wait until the request would be visible (k+3).
    task automatic pulse_to_req(input logic [4:0] lines);
        drive(lines, 8'h00, 0, 0, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        step();
        step();
    endtask

    initial begin
        // in, data, ml, ei, di, ack, done | irq, irq_no, pending, vector
        vecs.push_back('{5'h00, 8'h1F, 1, 1, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h08, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h08, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 1, 5'h08, 5'h08, 16'hFFF8});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'h08, 5'h00, 16'hFFF8});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'h08, 5'h00, 16'hFFF8});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h12, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h12, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h12, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h12, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 1, 5'h02, 5'h12, 16'hFFF4});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'h02, 5'h10, 16'hFFF4});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 5'h10, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 1, 5'h10, 5'h10, 16'hFFFA});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 1, 0, 0, 5'h10, 5'h00, 16'hFFFA});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h01, 16'hFFFE});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 0, 1, 5'h01, 5'h01, 16'hFFF2});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 1, 0, 0, 5'h01, 5'h00, 16'hFFF2});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 1, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h01, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});
        vecs.push_back('{5'h00, 8'h00, 0, 0, 0, 0, 0, 0, 5'h00, 5'h00, 16'hFFFE});

        // Reset state.
        rst = 1'b0;
        step();
        step();
        chk_outs("reset", 0, 5'h00, 5'h00);
        chk_state("reset", ST_IDLE);
        rst = 1'b1;

        // Table: single line service, simultaneous rise, held-high line.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].in_v, vecs[i].d, vecs[i].ml, vecs[i].e, vecs[i].dd,
                  vecs[i].ack, vecs[i].done);
            step();
            chk($sformatf("row%0d.irq", i), 16'(irq), 16'(vecs[i].e_irq));
            chk($sformatf("row%0d.irq_no", i), 16'(irq_no), 16'(vecs[i].e_no));
            chk($sformatf("row%0d.pending", i), 16'(pending), 16'(vecs[i].e_pend));
            chk($sformatf("row%0d.vector", i), vector, vecs[i].e_vec);
        end

        // Masked line still latches; unmasking raises irq one edge later.
        drive(5'h00, 8'h00, 1, 0, 0, 0, 0);
        step();
        pulse_to_req(5'h01);
        chk_outs("masked", 0, 5'h00, 5'h01);
        drive(5'h00, 8'h01, 1, 0, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("unmask", 1, 5'h01, 5'h01);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        chk_outs("unmask_done", 0, 5'h00, 5'h00);
        drive(5'h00, 8'h1F, 1, 0, 0, 0, 0);
        step();

        // di withdraws a request; ei brings it back.
        pulse_to_req(5'h04);
        chk_outs("l2_req", 1, 5'h04, 5'h04);
        chk_state("l2_req", ST_REQ);
        drive(5'h00, 8'h00, 0, 0, 1, 0, 0);
        step();
        chk_outs("di_withdraw", 0, 5'h00, 5'h04);
        chk_state("di_withdraw", ST_IDLE);
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("gie_off", 0, 5'h00, 5'h04);
        drive(5'h00, 8'h00, 0, 1, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("ei_rearm", 1, 5'h04, 5'h04);

        // Ack wins over di in the same cycle.
        drive(5'h00, 8'h00, 0, 0, 1, 1, 0);
        step();
        chk_outs("ack_vs_di", 0, 5'h04, 5'h00);
        chk_state("ack_vs_di", ST_SERVICE);
        drive(5'h00, 8'h00, 0, 1, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        chk_state("ack_vs_di_done", ST_IDLE);

        // Clearing the latched line's mask bit withdraws the request.
        pulse_to_req(5'h04);
        drive(5'h00, 8'h1B, 1, 0, 0, 0, 0);
        step();
        chk_outs("mask_drop", 0, 5'h00, 5'h04);
        drive(5'h00, 8'h1F, 1, 0, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("mask_restore", 1, 5'h04, 5'h04);

        // Higher-priority arrival waits while in REQ.
        pulse_to_req(5'h01);
        chk_outs("no_rearb", 1, 5'h04, 5'h05);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        chk_outs("no_rearb_ack", 0, 5'h04, 5'h01);
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("waited_line0", 1, 5'h01, 5'h01);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        chk_outs("waited_done", 0, 5'h00, 5'h00);

        // New edge on line 2 in the same cycle as its ack: pending stays set.
        pulse_to_req(5'h04);
        drive(5'h04, 8'h00, 0, 0, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("race_pre", 1, 5'h04, 5'h04);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        chk_outs("race_ack", 0, 5'h04, 5'h04);
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("race_again", 1, 5'h04, 5'h04);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 1);
        step();
        chk_outs("race_done", 0, 5'h00, 5'h00);

        // Reset mid-SERVICE with int_in[4] held high through reset.
        pulse_to_req(5'h18);
        chk_outs("svc_pre", 1, 5'h08, 5'h18);
        drive(5'h00, 8'h00, 0, 0, 0, 1, 0);
        step();
        chk_state("svc_pre", ST_SERVICE);
        drive(5'h10, 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk_outs("svc_reset", 0, 5'h00, 5'h00);
        chk_state("svc_reset", ST_IDLE);
        drive(5'h10, 8'h00, 0, 1, 0, 0, 0);
        step();
        drive(5'h10, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("held_r2", 0, 5'h00, 5'h00);
        step();
        chk_outs("held_r3", 0, 5'h00, 5'h10);
        drive(5'h10, 8'h00, 0, 0, 0, 0, 1);
        step();
        chk_outs("late_done", 0, 5'h00, 5'h10);
        chk_state("late_done", ST_IDLE);
        drive(5'h00, 8'h10, 1, 0, 0, 0, 0);
        step();
        drive(5'h00, 8'h00, 0, 0, 0, 0, 0);
        step();
        chk_outs("post_reset_req", 1, 5'h10, 5'h10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  reset; one clock; reset is synchronous and active-low.
REQ-003 int_in  in  5  external interrupt lines, asynchronous, active high, rising-edge triggered.
REQ-004 data  in  8  internal data bus; bits 4:0 are the mask source, bits 7:5 ignored.
REQ-005 mask_load  in  1  when high, mask register <= data[4:0].
REQ-006 ei  in  1  when high, global enable <= 1.
REQ-007 di  in  1  when high, global enable <= 0; di wins over ei.
REQ-008 int_ack  in  1  one-cycle pulse from control unit accepting the request.
REQ-009 int_done  in  1  one-cycle pulse from control unit at return-from-interrupt.
REQ-010 irq  out  1  interrupt request to control unit, registered.
REQ-011 irq_no  out  5  one-hot selected line, registered; 0 when none.
REQ-012 vector  out  16  handler address for irq_no, combinational from irq_no.
REQ-013 pending  out  5  pending register, for status reads.

Function
REQ-014 Each int_in line passes through a 2-flop synchronizer plus a history flop; edge = sync2 & ~hist.
REQ-015 int_in[i] first high at edge k, low at k-1 -> pending[i]=1 after edge k+2.
REQ-016 Mask bit 1 = line enabled; masked lines still latch into pending.
REQ-017 Eligible = pending & mask, gated by global enable.
REQ-018 Priority is fixed: bit 0 highest, bit 4 lowest.
REQ-019 States: IDLE, REQ, SERVICE; 2-bit encoding.
REQ-020 IDLE -> REQ when eligible != 0.
- irq_no <= highest-priority eligible line; irq <= 1.
- irq is high 1 edge after pending is set (edge k+3 per REQ-015).
REQ-021 In REQ with int_ack=1:
- pending[irq_no] cleared.
- irq <= 0.
- -> SERVICE; irq_no held.
REQ-022 In REQ, no ack, and (di=1, or mask bit of latched line cleared by mask_load) -> IDLE; irq <= 0; irq_no <= 0; pending unchanged.
REQ-023 int_ack in REQ together with di or a mask change: ack wins.
REQ-024 irq_no is not re-arbitrated while in REQ; a higher-priority arrival waits.
REQ-025 SERVICE: irq=0, irq_no held; int_done -> IDLE and irq_no <= 0; nesting is not supported.
REQ-026 int_ack outside REQ is ignored; int_done outside SERVICE is ignored.
REQ-027 An edge on the line being cleared by ack in the same cycle leaves pending[i]=1 (set wins).
REQ-028 vector values:
- one-hot bit 0..4 -> FFF2, FFF4, FFF6, FFF8, FFFA.
- irq_no = 0 -> FFFE.
REQ-029 A held-high int_in produces one pending set only; a new event needs low then high.

Reset
REQ-030 rst=0 at an edge gives:
- state IDLE; irq=0; irq_no=0.
- pending=0; mask=0; global enable=0.
- synchronizer and history flops = 0.
REQ-031 Reset applies from any state, including mid-REQ or mid-SERVICE.
REQ-032 An int_in held high through reset registers one edge after release.

Structure
REQ-033 Shared package contents:
- line count 5; state encodings.
- vector base FFF2, vector stride 2, default vector FFFE.
REQ-034 Sub-module int_sync_edge: per-line synchronizer + edge detector, instantiated 5 times.
REQ-035 Arbitration and the FSM live in the top module.

Verification
REQ-036 Setup: mask=1F, ei, pulse int_in[3] -> pending=08 at k+2; irq=1, irq_no=08, vector=FFF8 at k+3; ack -> pending=00, SERVICE; done -> IDLE, irq_no=00.
REQ-037 Setup: mask=1F, ei; int_in[4] and [1] rise together -> irq_no=02, vector=FFF4; after ack+done -> irq_no=10, vector=FFFA.
REQ-038 Setup: mask=00, ei, pulse int_in[0] -> pending=01, irq=0; mask_load data=01 -> irq=1 next edge, irq_no=01.
REQ-039 Setup: in REQ on line 2, assert di without ack -> IDLE next edge, irq=0, pending=04 kept; ei -> irq=1 again.
REQ-040 Setup: in REQ on line 2, di and int_ack same edge -> SERVICE, pending[2]=0.
REQ-041 Setup: in SERVICE, rst=0 for one edge -> irq=0, irq_no=00, pending=00, mask=00; later int_done has no effect.
